// File: rtl/core_host_driver.sv
// Host-side driver for a streaming core. It takes one job descriptor, issues
// the command word, streams nIn source words into the core, and collects nOut
// result words to the sink. Both data sides run concurrently during the
// transfer phase, and each stops on its own once its target is reached.
module core_host_driver #(
    parameter int CMD_W  = 16,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // job descriptor
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [CMD_W-1:0]  job_cmd,
    input  logic [CNT_W-1:0]  job_nIn,
    input  logic [CNT_W-1:0]  job_nOut,
    // upstream source
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    // downstream sink
    output logic [DATA_W-1:0] snk_data,
    output logic              snk_valid,
    input  logic              snk_ready,
    // core command channel
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_hasAny,
    input  logic              cmd_consume,
    // core input channel
    output logic [DATA_W-1:0] in,
    output logic              in_isReady,
    input  logic              in_canReceive,
    // core output channel
    input  logic [DATA_W-1:0] out,
    input  logic              out_isReady,
    output logic              out_canReceive,
    // status
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CMD_W-1:0]  cmd_reg, cmd_next;
    logic [CNT_W-1:0]  n_in_reg, n_in_next;
    logic [CNT_W-1:0]  n_out_reg, n_out_next;
    logic [CNT_W-1:0]  in_cnt_reg, in_cnt_next;
    logic [CNT_W-1:0]  out_cnt_reg, out_cnt_next;

    logic in_more;
    logic out_more;
    logic in_xfer;
    logic in_fire;
    logic out_fire;

    // Each side stays open only while it still owes words, so the counters
    // can never pass their targets and cannot wrap even at the maximum count.
    assign in_xfer  = (state_reg == S_XFER);
    assign in_more  = (in_cnt_reg < n_in_reg);
    assign out_more = (out_cnt_reg < n_out_reg);

    // Input side: source straight through to the core, no added latency.
    assign in             = in_xfer ? src_data : '0;
    assign in_isReady     = in_xfer & src_valid & in_more;
    assign src_ready      = in_xfer & in_canReceive & in_more;

    // Output side: core straight through to the sink; excess core output
    // stays unconsumed because out_canReceive drops once nOut is reached.
    assign snk_data       = in_xfer ? out : '0;
    assign snk_valid      = in_xfer & out_isReady & out_more;
    assign out_canReceive = in_xfer & snk_ready & out_more;

    assign in_fire  = in_isReady & in_canReceive;
    assign out_fire = out_isReady & out_canReceive;

    // Command is presented only while waiting for the core to take it.
    assign cmd_hasAny = (state_reg == S_CMD);
    assign cmd        = (state_reg == S_CMD) ? cmd_reg : '0;

    // job_ready is qualified with rst_n so it drops the moment reset asserts.
    assign job_ready = rst_n & (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);

    // State, latched descriptor and word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cmd_reg     <= '0;
            n_in_reg    <= '0;
            n_out_reg   <= '0;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cmd_reg     <= cmd_next;
            n_in_reg    <= n_in_next;
            n_out_reg   <= n_out_next;
            in_cnt_reg  <= in_cnt_next;
            out_cnt_reg <= out_cnt_next;
        end
    end

    // Job sequencing: accept, issue command, stream both sides, pulse done.
    always_comb begin
        state_next   = state_reg;
        cmd_next     = cmd_reg;
        n_in_next    = n_in_reg;
        n_out_next   = n_out_reg;
        in_cnt_next  = in_cnt_reg;
        out_cnt_next = out_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (job_valid) begin
                    cmd_next   = job_cmd;
                    n_in_next  = job_nIn;
                    n_out_next = job_nOut;
                    state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_consume) begin
                    in_cnt_next  = '0;
                    out_cnt_next = '0;
                    if ((n_in_reg == '0) && (n_out_reg == '0)) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (in_fire) begin
                    in_cnt_next = in_cnt_reg + CNT_W'(1);
                end
                if (out_fire) begin
                    out_cnt_next = out_cnt_reg + CNT_W'(1);
                end
                // Finishing edge may carry the last word of both sides at once.
                if ((in_cnt_next == n_in_reg) && (out_cnt_next == n_out_reg)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_host_driver.sv
// Bench for core_host_driver: directed job scenarios followed by a long
// randomized run. A job-level model (words still owed per side, command
// pending, done pending) predicts every output on every cycle.
module tb_core_host_driver;

    logic        clk;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_cmd;
    logic [15:0] job_nIn;
    logic [15:0] job_nOut;
    logic [63:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [63:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [15:0] cmd;
    logic        cmd_hasAny;
    logic        cmd_consume;
    logic [63:0] in;
    logic        in_isReady;
    logic        in_canReceive;
    logic [63:0] out;
    logic        out_isReady;
    logic        out_canReceive;
    logic        busy;
    logic        done;

    core_host_driver #(.CMD_W(16), .DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_cmd(job_cmd),
        .job_nIn(job_nIn), .job_nOut(job_nOut),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .cmd(cmd), .cmd_hasAny(cmd_hasAny), .cmd_consume(cmd_consume),
        .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
        .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // model: job-level bookkeeping
    bit          m_active   = 0;
    bit          m_cmd_out  = 0;
    bit          m_done_now = 0;
    int          m_in_left  = 0;
    int          m_out_left = 0;
    logic [15:0] m_cmd      = '0;

    // observation log
    logic [63:0] core_rx[$];
    logic [63:0] sink_rx[$];
    logic [63:0] cmd_log[$];
    int cycle         = 0;
    int has_cnt       = 0;
    int done_cnt      = 0;
    int acc_cnt       = 0;
    int data_fires    = 0;
    int last_fire_cyc = -1;
    int done_cyc      = -1;

    // queue-driven source/core-output stimulus for directed scenarios
    bit          q_mode  = 1;
    bit          src_pop = 0;
    bit          out_pop = 0;
    logic [63:0] src_q[$];
    logic [63:0] out_q[$];
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic chk_q(input string name, input logic [63:0] q[$], input logic [63:0] e[$]);
        chk({name, "_count"}, 64'(q.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            chk(name, (i < q.size()) ? q[i] : 64'hx, e[i]);
        end
    endtask

    task automatic clear_log();
        core_rx.delete();
        sink_rx.delete();
        cmd_log.delete();
        has_cnt = 0; done_cnt = 0; acc_cnt = 0; data_fires = 0;
        last_fire_cyc = -1; done_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (q_mode) begin
            if (src_pop && src_q.size() > 0) void'(src_q.pop_front());
            if (out_pop && out_q.size() > 0) void'(out_q.pop_front());
            src_valid   = (src_q.size() > 0);
            src_data    = src_valid ? src_q[0] : 64'd0;
            out_isReady = (out_q.size() > 0);
            out         = out_isReady ? out_q[0] : 64'd0;
        end
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        bit ok;
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (job_ready && !busy) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got busy expected idle within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic run_job(input string name, input logic [15:0] c, input int nin, input int nout);
        job_cmd = c; job_nIn = 16'(nin); job_nOut = 16'(nout);
        job_valid = 1; step();
        job_valid = 0; cmd_consume = 1; step();
        cmd_consume = 0;
        wait_idle(name, 60);
    endtask

    // Per-cycle compare against the model, then advance the model.
    initial begin : mon
        logic        e_rdy, e_has, e_xf, e_inr, e_srr, e_snv, e_ocr, e_busy, e_done;
        logic [15:0] e_cmd;
        logic [63:0] e_in, e_snk;
        forever begin
            @(negedge clk);
            cycle++;
            e_rdy = 0; e_has = 0; e_xf = 0; e_inr = 0; e_srr = 0; e_snv = 0;
            e_ocr = 0; e_busy = 0; e_done = 0; e_cmd = '0; e_in = '0; e_snk = '0;
            if (rst_n) begin
                e_xf   = m_active && !m_cmd_out;
                e_rdy  = !m_active && !m_done_now;
                e_has  = m_active && m_cmd_out;
                e_cmd  = e_has ? m_cmd : 16'd0;
                e_inr  = e_xf && src_valid && (m_in_left > 0);
                e_srr  = e_xf && in_canReceive && (m_in_left > 0);
                e_snv  = e_xf && out_isReady && (m_out_left > 0);
                e_ocr  = e_xf && snk_ready && (m_out_left > 0);
                e_in   = e_xf ? src_data : 64'd0;
                e_snk  = e_xf ? out : 64'd0;
                e_busy = m_active || m_done_now;
                e_done = m_done_now;
            end
            chk("job_ready",      64'(job_ready),      64'(e_rdy));
            chk("cmd_hasAny",     64'(cmd_hasAny),     64'(e_has));
            chk("cmd",            64'(cmd),            64'(e_cmd));
            chk("in_isReady",     64'(in_isReady),     64'(e_inr));
            chk("src_ready",      64'(src_ready),      64'(e_srr));
            chk("in",             in,                  e_in);
            chk("snk_valid",      64'(snk_valid),      64'(e_snv));
            chk("out_canReceive", 64'(out_canReceive), 64'(e_ocr));
            chk("snk_data",       snk_data,            e_snk);
            chk("busy",           64'(busy),           64'(e_busy));
            chk("done",           64'(done),           64'(e_done));

            src_pop = src_valid && src_ready;
            out_pop = out_isReady && out_canReceive;
            if (in_isReady && in_canReceive) begin
                core_rx.push_back(in); data_fires++; last_fire_cyc = cycle;
            end
            if (snk_valid && snk_ready) begin
                sink_rx.push_back(snk_data); data_fires++; last_fire_cyc = cycle;
            end
            if (cmd_hasAny) has_cnt++;
            if (cmd_hasAny && cmd_consume) cmd_log.push_back(64'(cmd));
            if (job_valid && job_ready) acc_cnt++;
            if (done) begin
                if (done_cnt == 0) done_cyc = cycle;
                done_cnt++;
            end

            if (!rst_n) begin
                m_active = 0; m_cmd_out = 0; m_done_now = 0;
                m_in_left = 0; m_out_left = 0; m_cmd = '0;
            end else if (m_done_now) begin
                m_done_now = 0;
            end else if (!m_active) begin
                if (job_valid) begin
                    m_active = 1; m_cmd_out = 1; m_cmd = job_cmd;
                    m_in_left = int'(job_nIn); m_out_left = int'(job_nOut);
                end
            end else if (m_cmd_out) begin
                if (cmd_consume) begin
                    m_cmd_out = 0;
                    if (m_in_left == 0 && m_out_left == 0) begin
                        m_active = 0; m_done_now = 1;
                    end
                end
            end else begin
                if (e_inr && in_canReceive) m_in_left--;
                if (e_snv && snk_ready) m_out_left--;
                if (m_in_left == 0 && m_out_left == 0) begin
                    m_active = 0; m_done_now = 1;
                end
            end
        end
    end

    initial begin : stim
        bit pat[4];
        rst_n = 0; job_valid = 0; job_cmd = '0; job_nIn = '0; job_nOut = '0;
        src_valid = 0; src_data = '0; snk_ready = 0; cmd_consume = 0;
        in_canReceive = 0; out_isReady = 0; out = '0;
        repeat (3) step();
        rst_n = 1;
        #1;
        chk("reset_release_ready", 64'(job_ready), 64'd1);
        step();

        // Zero-length job: command only, consumed in its third cycle.
        clear_log();
        job_cmd = 16'h0123; job_nIn = 0; job_nOut = 0; job_valid = 1;
        step();
        job_valid = 0;
        chk("A_cmd_value", 64'(cmd), 64'h0123);
        step(); step();
        cmd_consume = 1; step();
        cmd_consume = 0;
        chk("A_done_pulse", 64'(done), 64'd1);
        chk("A_cmd_zero", 64'(cmd), 64'd0);
        step(); step();
        chk("A_hasany_cycles", 64'(has_cnt), 64'd3);
        chk("A_done_count", 64'(done_cnt), 64'd1);
        chk("A_data_fires", 64'(data_fires), 64'd0);

        // Three input words with the core stalling one cycle; a fourth word waits.
        clear_log();
        src_q = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        job_cmd = 16'h0B01; job_nIn = 3; job_nOut = 0; job_valid = 1;
        step();
        job_valid = 0; cmd_consume = 1; step();
        cmd_consume = 0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            in_canReceive = pat[i];
            step();
        end
        chk("B_done_pulse", 64'(done), 64'd1);
        chk("B_src_ready_after_third", 64'(src_ready), 64'd0);
        step(); step();
        exp_q = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
        chk_q("B_core_rx", core_rx, exp_q);
        chk("B_src_left", 64'(src_q.size()), 64'd1);
        src_q.delete(); in_canReceive = 0; step();

        // Two output words with a one-cycle sink stall; a third is left unread.
        clear_log();
        out_q = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC};
        job_cmd = 16'h0C02; job_nIn = 0; job_nOut = 2; job_valid = 1;
        step();
        job_valid = 0; cmd_consume = 1; step();
        cmd_consume = 0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            snk_ready = pat[i];
            step();
        end
        snk_ready = 1;
        #1;
        chk("C_done_pulse", 64'(done), 64'd1);
        chk("C_ocr_while_cc", 64'(out_canReceive), 64'd0);
        step();
        chk("C_ocr_idle_cc", 64'(out_canReceive), 64'd0);
        exp_q = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
        chk_q("C_sink_rx", sink_rx, exp_q);
        chk("C_out_left", 64'(out_q.size()), 64'd1);
        out_q.delete(); snk_ready = 0; step();

        // Last input and last output complete on the same edge.
        clear_log();
        src_q = {64'h0000_0000_0000_0D01, 64'h0000_0000_0000_0D02};
        out_q = {64'h0000_0000_0000_0E01, 64'h0000_0000_0000_0E02};
        in_canReceive = 1; snk_ready = 1;
        step();
        run_job("D", 16'h0D00, 2, 2);
        chk("D_done_count", 64'(done_cnt), 64'd1);
        chk("D_done_latency", 64'(done_cyc - last_fire_cyc), 64'd1);
        chk("D_fires", 64'(data_fires), 64'd4);

        // Reset mid-transfer, then a fresh job.
        clear_log();
        src_q = {64'h5, 64'h6, 64'h7, 64'h8};
        in_canReceive = 1; snk_ready = 0;
        job_cmd = 16'h0E00; job_nIn = 4; job_nOut = 0; job_valid = 1;
        step();
        job_valid = 0; cmd_consume = 1; step();
        cmd_consume = 0; step();
        rst_n = 0;
        #1;
        chk("E_reset_cmd", 64'(cmd), 64'd0);
        chk("E_reset_busy", 64'(busy), 64'd0);
        chk("E_reset_ready", 64'(job_ready), 64'd0);
        step(); step();
        rst_n = 1;
        #1;
        chk("E_ready_after_release", 64'(job_ready), 64'd1);
        chk("E_no_done", 64'(done_cnt), 64'd0);
        chk("E_one_word_before_reset", 64'(core_rx.size()), 64'd1);
        src_q.delete(); step();
        clear_log();
        src_q = {64'h0000_0000_0000_0F01};
        out_q = {64'h0000_0000_0000_0F02};
        snk_ready = 1;
        step();
        run_job("E2", 16'h0F00, 1, 1);
        chk("E2_done_count", 64'(done_cnt), 64'd1);
        exp_q = {64'h0000_0000_0000_0F01};
        chk_q("E2_core_rx", core_rx, exp_q);
        exp_q = {64'h0000_0000_0000_0F02};
        chk_q("E2_sink_rx", sink_rx, exp_q);

        // job_valid held across back-to-back jobs; descriptor changes mid-job.
        clear_log();
        src_q = {64'h10, 64'h20, 64'h30};
        in_canReceive = 1; cmd_consume = 1;
        job_cmd = 16'h00A1; job_nIn = 1; job_nOut = 0; job_valid = 1;
        step();
        job_cmd = 16'h00B2; job_nIn = 2;
        for (int i = 0; i < 20 && acc_cnt < 2; i++) step();
        job_valid = 0;
        wait_idle("F", 40);
        cmd_consume = 0; step();
        chk("F_accepts", 64'(acc_cnt), 64'd2);
        chk("F_done_count", 64'(done_cnt), 64'd2);
        exp_q = {64'h00A1, 64'h00B2};
        chk_q("F_cmd_log", cmd_log, exp_q);
        exp_q = {64'h10, 64'h20, 64'h30};
        chk_q("F_core_rx", core_rx, exp_q);

        // Randomized run checked cycle by cycle against the model.
        q_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            job_valid     = 1'($urandom_range(0, 1));
            job_cmd       = 16'($urandom);
            job_nIn       = 16'($urandom_range(0, 4));
            job_nOut      = 16'($urandom_range(0, 4));
            src_valid     = 1'($urandom_range(0, 1));
            src_data      = {$urandom, $urandom};
            in_canReceive = 1'($urandom_range(0, 1));
            out_isReady   = 1'($urandom_range(0, 1));
            out           = {$urandom, $urandom};
            snk_ready     = 1'($urandom_range(0, 1));
            cmd_consume   = ($urandom_range(0, 2) != 0);
            rst_n         = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_host_driver.md
CORE_HOST_DRIVER -- requirements
Module: core_host_driver

Interface
REQ-001 SHALL have parameter CMD_W, default 16, meaning the width of the core command word ({which, cmd}).
REQ-002 SHALL have parameter DATA_W, default 64, meaning the width of the data word.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the per-job word counters.
REQ-004 SHALL have port clk  in  1  the single clock, rising-edge active.
REQ-005 SHALL have port rst_n  in  1  the reset, asynchronous and active-low.
REQ-006 SHALL have port job_valid  in  1  the job descriptor is present.
REQ-007 SHALL have port job_ready  out  1  the driver accepts a job.
REQ-008 SHALL have port job_cmd  in  CMD_W  the command word to issue to the core.
REQ-009 SHALL have port job_nIn  in  CNT_W  the number of input words to stream.
REQ-010 SHALL have port job_nOut  in  CNT_W  the number of output words to collect.
REQ-011 SHALL have port src_data / src_valid / src_ready  in / in / out  DATA_W / 1 / 1  the upstream data source.
REQ-012 SHALL have port snk_data / snk_valid / snk_ready  out / out / in  DATA_W / 1 / 1  the downstream result sink.
REQ-013 SHALL have port cmd / cmd_hasAny / cmd_consume  out / out / in  CMD_W / 1 / 1  the core command channel.
REQ-014 SHALL have port in / in_isReady / in_canReceive  out / out / in  DATA_W / 1 / 1  the core input channel.
REQ-015 SHALL have port out / out_isReady / out_canReceive  in / in / out  DATA_W / 1 / 1  the core output channel.
REQ-016 SHALL have port busy / done  out / out  1 / 1  busy is high outside IDLE; done is a one-cycle pulse at job end.

Function
REQ-017 SHALL transfer on any channel only on a rising clk edge where both sides of that channel's pair are high.
REQ-018 SHALL implement the states IDLE, CMD, XFER and DONE.
REQ-019 SHALL hold job_ready=1 only in IDLE, and on acceptance latch cmd, nIn and nOut and enter CMD.
REQ-020 SHALL, in CMD, drive cmd_hasAny=1 with cmd equal to the latched value, holding cmd stable until cmd_consume is sampled high, with cmd=0 at all other times.
REQ-021 SHALL, on cmd_consume in CMD, clear both counters and enter XFER, or enter DONE if nIn=0 and nOut=0.
REQ-022 SHALL treat the input and output sides as concurrent and independent in XFER.
REQ-023 SHALL drive the input side as: in=src_data; in_isReady=src_valid & (inCnt<nIn); src_ready=in_canReceive & (inCnt<nIn). This path is combinational, with no added latency.
REQ-024 SHALL drive the output side as: snk_data=out; snk_valid=out_isReady & (outCnt<nOut); out_canReceive=snk_ready & (outCnt<nOut). This path is combinational.
REQ-025 SHALL increment inCnt on each input transfer and outCnt on each output transfer, and SHALL never increment either counter past its latched target.
REQ-026 SHALL leave XFER for DONE in the cycle after both counts reach their targets, including when the last input and last output transfer on the same edge.
REQ-027 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE with job_ready=1 in the next cycle.
REQ-028 SHALL keep in_isReady, src_ready, snk_valid and out_canReceive at 0 outside XFER; core output arriving before XFER or beyond nOut SHALL not be consumed.
REQ-029 SHALL hold the minimum job latency, accept to done, at 3 cycles plus the transfer cycles.
REQ-030 SHALL allow nIn or nOut up to 2^CNT_W-1, with no counter wrap-around.

Reset
REQ-031 SHALL, with rst_n low, immediately and asynchronously force state IDLE, zero the counters and latches, drive cmd=0, and set every handshake output, busy and done to 0.
REQ-032 SHALL raise job_ready to 1 in the first cycle after rst_n deasserts.
REQ-033 SHALL abandon any job in progress when reset occurs mid-operation, with no partial done.

Verification
REQ-034 SHALL cover this scenario: job cmd=0x0123, nIn=0, nOut=0; consume after 2 cycles -> cmd_hasAny high for 3 cycles, then done pulse, with no data handshakes.
REQ-035 SHALL cover this scenario: nIn=3, nOut=0; source words 0x1111..., 0x2222..., 0x3333...; in_canReceive toggling 1,0,1,1 -> core receives exactly those 3 words in order, and src_ready is never high after the third.
REQ-036 SHALL cover this scenario: nIn=0, nOut=2; core offers 0xAA.., 0xBB.., 0xCC..; snk_ready stalls 1 cycle -> sink gets 0xAA.., 0xBB.. only, and out_canReceive=0 while 0xCC.. is offered.
REQ-037 SHALL cover this scenario: nIn=2, nOut=2 with the last input and last output transferring on the same edge -> done exactly once, one cycle later.
REQ-038 SHALL cover this scenario: rst_n pulsed low mid-XFER after 1 of 4 inputs -> all outputs 0 during reset, no done, job_ready=1 after release, and a new job runs correctly.
REQ-039 SHALL cover this scenario: job_valid held high across consecutive jobs -> the second job is accepted only in IDLE after done, and the latched values do not change when job_* changes mid-job.
